addroundkey: RTL and testbench
==============================

# addroundkey

Registered AddRoundKey stage of the AES encryption datapath, sitting directly downstream of the MixColumns stage. It takes MixColumns' 128-bit result on an enable pulse and assembles the matching 128-bit round key from four 32-bit key-schedule words received over a valid/ready handshake. It XORs the two, presents the result with a one-cycle finished pulse, and tracks the round index 0..10 for the round controller.

## Interface
Parameters:
- NUM_ROUNDS, default 10, meaning: index of the final round; the round counter wraps after it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- addkey_enable  input  1  request strobe from the round controller; wired in parallel with the mixcol_finished handshake.
- olddata  input  128  state from MixColumns, in row-major byte order: byte (r,c) occupies bits [127-8*(4r+c) -: 8].
- key_word  input  32  one key-schedule word w[j], i.e. column j of the round key; k0 is in bits 31:24.
- key_valid  input  1  key_word is valid.
- key_ready  output  1  the stage accepts a key word this cycle.
- newdata  output  128  the state XOR the round key, in row-major order; holds until the next completion.
- addkey_finished  output  1  one-cycle pulse; newdata is valid.
- round_num  output  4  round index that the next completion will use.
- last_round  output  1  high when round_num == NUM_ROUNDS.

## Operation
State machine:
- IDLE: addkey_enable=1 → latch olddata into data_reg; go to HAVE_DATA.
- HAVE_DATA: key_cnt==4 (registered value) → do the XOR and finish; go to IDLE. Otherwise stay in HAVE_DATA.

Key buffer:
- key_ready = (key_cnt < 4). The buffer fills independently of the state machine.
- An accept occurs when key_valid && key_ready. On each accept, word j = key_cnt is stored in column j:
  - row r byte of column j ← key_word[31-8r -: 8].
  - key_cnt increments.
- The buffer has no overflow. With key_cnt==4, key_ready is low and key_valid is ignored.

Completion edge:
- newdata ← data_reg ^ key_reg.
- addkey_finished ← 1 for one cycle.
- key_cnt ← 0.
- round_num ← (round_num == NUM_ROUNDS) ? 0 : round_num + 1.

Ignored inputs:
- addkey_enable in HAVE_DATA is ignored; data_reg is not overwritten.
- olddata is sampled only on the IDLE accept edge.

Arithmetic: pure bytewise XOR; no carries, no width growth.

Reset (n_rst=0 at an edge), including mid-operation:
- state=IDLE; key_cnt=0; data_reg, key_reg and newdata = 0; addkey_finished=0; round_num=0.
- Hence key_ready=1 and last_round=0 after reset.
- Any partially loaded key and any latched data are discarded.
- Reset has priority over every other event on the same edge.

## Timing
Latency:
- addkey_enable is sampled at edge k with the key already full: newdata and addkey_finished are visible after edge k+1. Latency is 2 edges from the enable edge.
- Key completes at edge m while in HAVE_DATA (4th word accepted at m): completion occurs at edge m+1.

Simultaneous events:
- A 4th key-word accept and the IDLE enable on the same edge are both taken; completion follows at the next edge.
- A key word arriving on the completion edge is not accepted, because key_ready is still low. The following cycle has key_ready=1 and key_cnt=0.

Outputs:
- addkey_finished is high for exactly one cycle per completion and is never high on consecutive cycles.
- last_round is combinational from round_num; it updates the cycle after the completion edge.

Back-to-back throughput: one completion per 5 edges when key words stream continuously (4 loads plus 1 XOR). Data may be latched during key loading.

## Test plan
1. FIPS-197 round-1 vector:
   - Stimulus: reset, then key words a0fafe17, 88542cb1, 23a33939, 2a6c7605 on consecutive cycles; then enable with olddata=04e0482866cbf8068119d326e59a7a4c.
   - Response: newdata=a4686b029c9f5b6a7f35ea50f22b4349; addkey_finished is one cycle wide, exactly 2 edges after the enable edge; round_num goes 0→1.
2. Data before key:
   - Stimulus: enable first; key words then arrive one per 2 cycles.
   - Response: finished occurs exactly 1 edge after the 4th accept; pulsing enable again while waiting leaves the result unchanged from test 1's value.
3. Key overflow:
   - Stimulus: hold key_valid high for 6 cycles with distinct words.
   - Response: key_ready drops after the 4th accept; only the first 4 words are used, as checked with olddata=0 (newdata equals the key in row-major order).
4. Round wrap:
   - Stimulus: 11 completions.
   - Response: last_round=1 while round_num=10; after the 11th completion, round_num=0 and last_round=0.
5. Reset mid-operation:
   - Stimulus: assert n_rst low after 2 key words plus an enable.
   - Response: next cycle shows key_ready=1, addkey_finished=0, newdata=0, round_num=0; a fresh test-1 sequence then reproduces test 1's result.
6. Random checks:
   - Stimulus: 200 random olddata/key pairs.
   - Response: newdata matches a bytewise-XOR model in every case; a key word offered on the completion edge is never accepted.

Source files
------------

// File: rtl/addroundkey.sv
// Registered AES AddRoundKey stage: latches the MixColumns state, gathers four
// key-schedule words into a round key, XORs them and tracks the round index.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for addkey_enable to latch olddata
// HAVE_DATA | state latched; completes once all four key words are buffered

module addroundkey #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         addkey_enable,
    input  logic [127:0] olddata,
    input  logic [31:0]  key_word,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] newdata,
    output logic         addkey_finished,
    output logic [3:0]   round_num,
    output logic         last_round
);

    typedef enum logic {
        IDLE,
        HAVE_DATA
    } state_t;

    state_t         r_state;
    logic [2:0]     r_key_cnt;
    logic [127:0]   r_data;
    logic [127:0]   r_key;
    logic [127:0]   r_newdata;
    logic           r_finished;
    logic [3:0]     r_round;

    logic           w_key_accept;

    assign key_ready       = (r_key_cnt < 3'd4);
    assign w_key_accept    = key_valid && key_ready;
    assign newdata         = r_newdata;
    assign addkey_finished = r_finished;
    assign round_num       = r_round;
    assign last_round      = (r_round == 4'(NUM_ROUNDS));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_key_cnt  <= 3'd0;
            r_data     <= '0;
            r_key      <= '0;
            r_newdata  <= '0;
            r_finished <= 1'b0;
            r_round    <= 4'd0;
        end else begin
            r_finished <= 1'b0;

            // Word j is column j of the row-major key matrix.
            if (w_key_accept) begin
                for (int c = 0; c < 4; c++) begin
                    if (r_key_cnt == 3'(c)) begin
                        for (int r = 0; r < 4; r++) begin
                            r_key[127-8*(4*r+c) -: 8] <= key_word[31-8*r -: 8];
                        end
                    end
                end
                r_key_cnt <= r_key_cnt + 3'd1;
            end

            case (r_state)
                IDLE: begin
                    if (addkey_enable) begin
                        r_data  <= olddata;
                        r_state <= HAVE_DATA;
                    end
                end
                HAVE_DATA: begin
                    // key_ready is low here, so no accept can collide with the clear.
                    if (r_key_cnt == 3'd4) begin
                        r_newdata  <= r_data ^ r_key;
                        r_finished <= 1'b1;
                        r_key_cnt  <= 3'd0;
                        r_round    <= (r_round == 4'(NUM_ROUNDS)) ? 4'd0 : r_round + 4'd1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addroundkey.sv
// Self-checking bench for addroundkey: scoreboard of expected results, pushed
// when the stimulus completes a data/key pair and popped on each finished pulse.

module tb_addroundkey;

    localparam int NUM_ROUNDS = 10;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         addkey_enable = 1'b0;
    logic [127:0] olddata = '0;
    logic [31:0]  key_word = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] newdata;
    logic         addkey_finished;
    logic [3:0]   round_num;
    logic         last_round;

    addroundkey #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .addkey_enable   (addkey_enable),
        .olddata         (olddata),
        .key_word        (key_word),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .newdata         (newdata),
        .addkey_finished (addkey_finished),
        .round_num       (round_num),
        .last_round      (last_round)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [127:0] sb[$];
    logic [3:0]   exp_round = 4'd0;
    logic         prev_fin = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Row-major matrix: byte (r,c) = word c, row r.
    function automatic logic [127:0] key_matrix(input logic [31:0] w0, w1, w2, w3);
        logic [31:0]  w[4];
        logic [127:0] m;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[127-8*(4*r+c) -: 8] = w[c][31-8*r -: 8];
        return m;
    endfunction

    always @(negedge clk) begin
        if (!n_rst) begin
            sb.delete();
            exp_round = 4'd0;
            prev_fin  = 1'b0;
        end else begin
            if (addkey_finished) begin
                check("fin_not_consecutive", prev_fin, 1'b0);
                if (sb.size() == 0) begin
                    check("sb_unexpected_finish", 1'b1, 1'b0);
                end else begin
                    check("newdata", newdata, sb.pop_front());
                end
                exp_round = (exp_round == 4'(NUM_ROUNDS)) ? 4'd0 : exp_round + 4'd1;
                check("round_num", 128'(round_num), 128'(exp_round));
            end
            prev_fin = addkey_finished;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // Drives at a negedge; returns one negedge later with key_valid low.
    task automatic put_key(input logic [31:0] w, output logic acc);
        key_valid = 1'b1;
        key_word  = w;
        acc       = key_ready;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_en(input logic [127:0] d);
        addkey_enable = 1'b1;
        olddata       = d;
        @(negedge clk);
        addkey_enable = 1'b0;
    endtask

    // Called one negedge after the triggering edge; want = edges to finish.
    task automatic wait_fin(input int want);
        int n;
        n = 1;
        while (!addkey_finished && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(want));
        @(negedge clk);
        check("fin_width", 128'(addkey_finished), 128'd0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_finished", 128'(addkey_finished), 128'd0);
        check("rst_newdata", newdata, 128'd0);
        check("rst_round", 128'(round_num), 128'd0);
        check("rst_last_round", 128'(last_round), 128'd0);
    endtask

    logic [31:0]  kw[4];
    logic [127:0] d1, e1;

    task automatic run_vector1();
        logic acc;
        for (int j = 0; j < 4; j++) begin
            put_key(kw[j], acc);
            check("v1_key_acc", 128'(acc), 128'd1);
        end
        sb.push_back(e1);
        pulse_en(d1);
        wait_fin(2);
    endtask

    initial begin
        logic acc;
        logic [31:0]  w[6];
        logic [31:0]  x;
        logic [127:0] d;
        bit           sim;

        kw[0] = 32'ha0fafe17; kw[1] = 32'h88542cb1;
        kw[2] = 32'h23a33939; kw[3] = 32'h2a6c7605;
        d1 = 128'h04e0482866cbf8068119d326e59a7a4c;
        e1 = 128'ha4686b029c9f5b6a7f35ea50f22b4349;

        @(negedge clk);
        @(negedge clk);
        do_reset();

        // FIPS-197 round-1 vector
        run_vector1();
        check("v1_newdata", newdata, e1);
        check("v1_round", 128'(round_num), 128'd1);

        // Data before key, with an ignored enable while waiting
        sb.push_back(e1);
        pulse_en(d1);
        for (int j = 0; j < 4; j++) begin
            put_key(kw[j], acc);
            check("dbk_key_acc", 128'(acc), 128'd1);
            if (j == 1) pulse_en(128'hdeadbeef_00112233_44556677_8899aabb);
            else if (j < 3) @(negedge clk);
        end
        wait_fin(2);
        check("dbk_newdata", newdata, e1);

        // Key overflow: valid held for 6 words
        for (int j = 0; j < 6; j++) w[j] = 32'h11111111 * (j + 1) + 32'h01020304;
        for (int j = 0; j < 6; j++) begin
            key_valid = 1'b1;
            key_word  = w[j];
            check("ovf_ready", 128'(key_ready), (j < 4) ? 128'd1 : 128'd0);
            @(negedge clk);
        end
        key_valid = 1'b0;
        sb.push_back(key_matrix(w[0], w[1], w[2], w[3]));
        pulse_en('0);
        wait_fin(2);
        check("ovf_newdata", newdata, key_matrix(w[0], w[1], w[2], w[3]));

        // Round wrap over 11 completions
        do_reset();
        for (int i = 0; i < 11; i++) begin
            check("wrap_round", 128'(round_num), 128'(i));
            check("wrap_last", 128'(last_round), (i == NUM_ROUNDS) ? 128'd1 : 128'd0);
            for (int j = 0; j < 4; j++) begin
                w[j] = $urandom;
                put_key(w[j], acc);
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back(d ^ key_matrix(w[0], w[1], w[2], w[3]));
            pulse_en(d);
            wait_fin(2);
        end
        check("wrap_round_end", 128'(round_num), 128'd0);
        check("wrap_last_end", 128'(last_round), 128'd0);

        // Reset mid-operation
        put_key(kw[0], acc);
        put_key(kw[1], acc);
        pulse_en(d1);
        do_reset();
        run_vector1();
        check("rst_v1_newdata", newdata, e1);

        // Random pairs; key word offered across the completion edge
        for (int it = 0; it < 200; it++) begin
            for (int j = 0; j < 4; j++) w[j] = $urandom;
            d   = {$urandom, $urandom, $urandom, $urandom};
            x   = $urandom;
            sim = $urandom_range(0, 1) == 1;
            sb.push_back(d ^ key_matrix(w[0], w[1], w[2], w[3]));
            for (int j = 0; j < 4; j++) begin
                key_valid = 1'b1;
                key_word  = w[j];
                check("rnd_ready", 128'(key_ready), 128'd1);
                if (sim && j == 3) begin
                    addkey_enable = 1'b1;
                    olddata       = d;
                end
                @(negedge clk);
                addkey_enable = 1'b0;
            end
            key_word = x;
            if (!sim) begin
                addkey_enable = 1'b1;
                olddata       = d;
                check("rnd_ready_full", 128'(key_ready), 128'd0);
                @(negedge clk);
                addkey_enable = 1'b0;
            end
            check("rnd_ready_on_done", 128'(key_ready), 128'd0);
            @(negedge clk);
            key_valid = 1'b0;
            check("rnd_finished", 128'(addkey_finished), 128'd1);
            check("rnd_ready_after", 128'(key_ready), 128'd1);
        end

        @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
